ddr_burst_tester: RTL and testbench

- AXI4 master that sequences write-then-read-back burst tests on the DDR port (axi_ram in simulation, MIG on board) and counts data mismatches.
- Sits beside the system top and is started by a CPU peripheral register.
- AxSIZE=log2(DATA_W/8), AxBURST=INCR and wstrb all-ones are tied off at the top level.

---
 rtl/ddr_burst_tester_if.sv | 71 +++++++
 rtl/ddr_burst_tester.sv | 203 ++++++++++++++++++++
 tb/tb_ddr_burst_tester.sv | 338 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ddr_burst_tester_if.sv
// rtl/ddr_burst_tester_if.sv - AXI4 write/read channel bundle for the DDR burst tester
//
// Purpose: groups the AXI4 master-side channel signals used by ddr_burst_tester.
//    AxSIZE, AxBURST and wstrb are tied off at the system top, so they are not carried here.
// Parameters: DATA_W (AXI data width), ADDR_W (AXI byte-address width).
// Signals: aw* (write address), w* (write data), b* (write response),
//    ar* (read address), r* (read data).
//    bresp/rresp exist only when DDR_TESTER_RESP_CHK_EN is defined.
// Modports: master (the tester), slave (the memory side / bench).

interface ddr_burst_tester_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 30
);
   logic [ADDR_W-1:0] awaddr;
   logic [7:0]        awlen;
   logic              awvalid;
   logic              awready;
   logic [DATA_W-1:0] wdata;
   logic              wlast;
   logic              wvalid;
   logic              wready;
   logic              bvalid;
   logic              bready;
   logic [ADDR_W-1:0] araddr;
   logic [7:0]        arlen;
   logic              arvalid;
   logic              arready;
   logic [DATA_W-1:0] rdata;
   logic              rlast;
   logic              rvalid;
   logic              rready;
`ifdef DDR_TESTER_RESP_CHK_EN
   logic [1:0]        bresp;
   logic [1:0]        rresp;
`endif

   modport master (
`ifdef DDR_TESTER_RESP_CHK_EN
      input  bresp,
      input  rresp,
`endif
      output awaddr, awlen, awvalid,
      input  awready,
      output wdata, wlast, wvalid,
      input  wready,
      input  bvalid,
      output bready,
      output araddr, arlen, arvalid,
      input  arready,
      input  rdata, rlast, rvalid,
      output rready
   );

   modport slave (
`ifdef DDR_TESTER_RESP_CHK_EN
      output bresp,
      output rresp,
`endif
      input  awaddr, awlen, awvalid,
      output awready,
      input  wdata, wlast, wvalid,
      output wready,
      output bvalid,
      input  bready,
      input  araddr, arlen, arvalid,
      output arready,
      output rdata, rlast, rvalid,
      input  rready
   );
endinterface

// File: rtl/ddr_burst_tester.sv
// rtl/ddr_burst_tester.sv - AXI4 write-then-read-back burst tester with mismatch counter
//
// Purpose: writes nbursts INCR bursts of an address-derived pattern to DDR, then reads
//    them back in the same order and counts data and rlast mismatches (saturating).
//    One transaction outstanding at a time; write phase completes before read phase.
// Parameters: DATA_W (data width, power of 2, >=32), ADDR_W (byte-address width),
//    BURST_LEN (beats per burst, 1..256).
// Ports:
//    clk, rst    - clock, asynchronous active-high reset
//    start       - one-cycle pulse, ignored while busy or when nbursts is 0
//    nbursts     - number of bursts, latched on an accepted start
//    busy        - test in progress
//    err_cnt     - saturating mismatch count
//    m_axi       - ddr_burst_tester_if master modport
// Optional: DDR_TESTER_RESP_CHK_EN adds bresp/rresp checking (non-OKAY counts as an error).

module ddr_burst_tester #(
   parameter int DATA_W    = 32,
   parameter int ADDR_W    = 30,
   parameter int BURST_LEN = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [15:0] nbursts,
   output logic        busy,
   output logic [15:0] err_cnt,
   ddr_burst_tester_if.master m_axi
);

   localparam int BYTES       = DATA_W / 8;
   localparam int BURST_BYTES = BURST_LEN * BYTES;
   localparam int BEAT_W      = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

   typedef enum logic [2:0] {
      IDLE,
      WADDR,
      WDATA,
      WRESP,
      RADDR,
      RDATA
   } state_t;

   state_t            state_q, state_d;
   logic [15:0]       nb_q, nb_d;
   logic [15:0]       bidx_q, bidx_d;
   logic [BEAT_W-1:0] beat_q, beat_d;
   logic [15:0]       err_q, err_d;
   logic [1:0]        err_inc;
   logic [16:0]       err_sum;

   logic [ADDR_W-1:0] burst_addr;
   logic [DATA_W-1:0] pattern;
   logic              last_beat;
   logic              last_burst;

   logic awvalid, wvalid, wlast, bready, arvalid, rready;

   // Modular arithmetic in the target width gives the required truncation for free.
   assign burst_addr = ADDR_W'(bidx_q) * ADDR_W'(BURST_BYTES);
   assign pattern    = DATA_W'(burst_addr) + DATA_W'(beat_q) * DATA_W'(BYTES);
   assign last_beat  = (beat_q == LAST_BEAT);
   assign last_burst = (bidx_q == nb_q - 16'd1);

   // Address and data are pure functions of the counters, which only move on a
   // handshake, so they stay stable while a valid waits for its ready.
   assign m_axi.awaddr  = burst_addr;
   assign m_axi.araddr  = burst_addr;
   assign m_axi.wdata   = pattern;
   assign m_axi.awlen   = 8'(BURST_LEN - 1);
   assign m_axi.arlen   = 8'(BURST_LEN - 1);
   assign m_axi.awvalid = awvalid;
   assign m_axi.wvalid  = wvalid;
   assign m_axi.wlast   = wlast;
   assign m_axi.bready  = bready;
   assign m_axi.arvalid = arvalid;
   assign m_axi.rready  = rready;

   assign busy    = (state_q != IDLE);
   assign err_cnt = err_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         nb_q   <= 16'd0;
         bidx_q <= 16'd0;
         beat_q <= '0;
         err_q  <= 16'd0;
      end else begin
         nb_q   <= nb_d;
         bidx_q <= bidx_d;
         beat_q <= beat_d;
         err_q  <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      nb_d    = nb_q;
      bidx_d  = bidx_q;
      beat_d  = beat_q;
      err_d   = err_q;
      err_inc = 2'd0;
      err_sum = 17'd0;
      awvalid = 1'b0;
      wvalid  = 1'b0;
      wlast   = 1'b0;
      bready  = 1'b0;
      arvalid = 1'b0;
      rready  = 1'b0;

      case (state_q)
         IDLE: begin
            if (start && (nbursts != 16'd0)) begin
               nb_d    = nbursts;
               err_d   = 16'd0;
               bidx_d  = 16'd0;
               beat_d  = '0;
               state_d = WADDR;
            end
         end
         WADDR: begin
            awvalid = 1'b1;
            if (m_axi.awready) begin
               state_d = WDATA;
            end
         end
         WDATA: begin
            wvalid = 1'b1;
            wlast  = last_beat;
            if (m_axi.wready) begin
               if (last_beat) begin
                  beat_d  = '0;
                  state_d = WRESP;
               end else begin
                  beat_d = beat_q + BEAT_W'(1);
               end
            end
         end
         WRESP: begin
            bready = 1'b1;
            if (m_axi.bvalid) begin
`ifdef DDR_TESTER_RESP_CHK_EN
               err_inc = 2'(m_axi.bresp != 2'b00);
`endif
               if (last_burst) begin
                  bidx_d  = 16'd0;
                  state_d = RADDR;
               end else begin
                  bidx_d  = bidx_q + 16'd1;
                  state_d = WADDR;
               end
            end
         end
         RADDR: begin
            arvalid = 1'b1;
            if (m_axi.arready) begin
               state_d = RDATA;
            end
         end
         RDATA: begin
            rready = 1'b1;
            if (m_axi.rvalid) begin
               // Data and rlast are judged independently; both wrong counts twice.
               err_inc = 2'(m_axi.rdata != pattern) + 2'(m_axi.rlast != last_beat);
`ifdef DDR_TESTER_RESP_CHK_EN
               err_inc = err_inc + 2'(m_axi.rresp != 2'b00);
`endif
               // The beat counter, not rlast, decides where a burst ends.
               if (last_beat) begin
                  beat_d = '0;
                  if (last_burst) begin
                     bidx_d  = 16'd0;
                     state_d = IDLE;
                  end else begin
                     bidx_d  = bidx_q + 16'd1;
                     state_d = RADDR;
                  end
               end else begin
                  beat_d = beat_q + BEAT_W'(1);
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (err_inc != 2'd0) begin
         err_sum = {1'b0, err_q} + 17'(err_inc);
         err_d   = err_sum[16] ? 16'hFFFF : err_sum[15:0];
      end
   end

endmodule

// File: tb/tb_ddr_burst_tester.sv
// tb/tb_ddr_burst_tester.sv - randomized self-checking bench for ddr_burst_tester

module tb_ddr_burst_tester;

   localparam int DATA_W    = 32;
   localparam int ADDR_W    = 30;
   localparam int BURST_LEN = 4;

   logic        clk;
   logic        rst;
   logic        start;
   logic [15:0] nbursts;
   logic        busy;
   logic [15:0] err_cnt;

   ddr_burst_tester_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) m_axi ();

   ddr_burst_tester #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BURST_LEN(BURST_LEN)) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .nbursts (nbursts),
      .busy    (busy),
      .err_cnt (err_cnt),
      .m_axi   (m_axi)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Memory model and scoreboard state
   logic [31:0] mem [int];
   int aw_n, ar_n, r_total, exp_err, cur_nb;
   int b_pending, r_left, r_beat, r_burst, w_k, aw_wait, ar_wait;
   logic [ADDR_W-1:0] w_base, r_addr_cur, prev_awaddr, prev_araddr;
   logic [DATA_W-1:0] prev_wdata, flip_mask;
   logic prev_wlast;
   bit prev_aw_stall, prev_w_stall, prev_ar_stall, rlast_flip;

   // Stimulus knobs
   int cfg_stall, cfg_hold, cfg_flip_mode, cfg_flip_pct, cfg_rlast_pct;
   bit cfg_toggle, cfg_restart;
`ifdef DDR_TESTER_RESP_CHK_EN
   int cfg_bresp_pct, cfg_rresp_pct;
`endif

   function automatic bit rnd_ok();
      return int'($urandom_range(0, 99)) >= cfg_stall;
   endfunction

   function automatic bit rnd_pct(input int pct);
      return int'($urandom_range(0, 99)) < pct;
   endfunction

   // Slave responder: inputs are set on the falling edge; a handshake seen here is the
   // one the DUT takes on the following rising edge.
   always @(negedge clk) begin
      if (rst) begin
         m_axi.awready = 1'b0;
         m_axi.wready  = 1'b0;
         m_axi.bvalid  = 1'b0;
         m_axi.arready = 1'b0;
         m_axi.rvalid  = 1'b0;
         m_axi.rlast   = 1'b0;
         m_axi.rdata   = '0;
`ifdef DDR_TESTER_RESP_CHK_EN
         m_axi.bresp   = 2'b00;
         m_axi.rresp   = 2'b00;
`endif
         b_pending = 0; r_left = 0; w_k = 0; aw_wait = 0; ar_wait = 0;
         prev_aw_stall = 0; prev_w_stall = 0; prev_ar_stall = 0; rlast_flip = 0;
      end else begin
         if (prev_aw_stall) begin
            check_eq("aw_valid_held", 64'(m_axi.awvalid), 64'(1));
            check_eq("aw_addr_held", 64'(m_axi.awaddr), 64'(prev_awaddr));
         end
         if (prev_w_stall) begin
            check_eq("w_valid_held", 64'(m_axi.wvalid), 64'(1));
            check_eq("w_data_held", 64'(m_axi.wdata), 64'(prev_wdata));
            check_eq("w_last_held", 64'(m_axi.wlast), 64'(prev_wlast));
         end
         if (prev_ar_stall) begin
            check_eq("ar_valid_held", 64'(m_axi.arvalid), 64'(1));
            check_eq("ar_addr_held", 64'(m_axi.araddr), 64'(prev_araddr));
         end

         m_axi.awready = (aw_wait >= cfg_hold) && rnd_ok();
         m_axi.arready = (ar_wait >= cfg_hold) && rnd_ok();
         m_axi.wready  = cfg_toggle ? !m_axi.wready : rnd_ok();
         m_axi.bvalid  = (b_pending > 0) && rnd_ok();
`ifdef DDR_TESTER_RESP_CHK_EN
         m_axi.bresp   = (m_axi.bvalid && rnd_pct(cfg_bresp_pct)) ? 2'b10 : 2'b00;
`endif
         if (r_left > 0 && rnd_ok()) begin
            flip_mask = '0;
            case (cfg_flip_mode)
               1: if (r_burst == 0 && r_beat == 2) flip_mask = 32'd1;
               2: flip_mask = 32'd1;
               3: if (rnd_pct(cfg_flip_pct)) flip_mask = 32'd1 << $urandom_range(0, 31);
               default: flip_mask = '0;
            endcase
            rlast_flip    = rnd_pct(cfg_rlast_pct);
            m_axi.rvalid  = 1'b1;
            m_axi.rdata   = (mem.exists(int'(r_addr_cur)) ? mem[int'(r_addr_cur)]
                                                          : ~{2'b00, r_addr_cur}) ^ flip_mask;
            m_axi.rlast   = (r_beat == BURST_LEN - 1) ^ rlast_flip;
`ifdef DDR_TESTER_RESP_CHK_EN
            m_axi.rresp   = rnd_pct(cfg_rresp_pct) ? 2'b11 : 2'b00;
`endif
         end else begin
            m_axi.rvalid = 1'b0;
            m_axi.rlast  = 1'b0;
         end

         if (m_axi.awvalid && m_axi.awready) begin
            check_eq("awaddr", 64'(m_axi.awaddr), 64'(aw_n * BURST_LEN * 4));
            check_eq("awlen", 64'(m_axi.awlen), 64'(BURST_LEN - 1));
            w_base  = m_axi.awaddr;
            w_k     = 0;
            aw_n++;
            aw_wait = 0;
         end else if (m_axi.awvalid) begin
            aw_wait++;
         end

         if (m_axi.wvalid && m_axi.wready) begin
            check_eq("wdata", 64'(m_axi.wdata), 64'({2'b00, w_base}) + 64'(w_k * 4));
            check_eq("wlast", 64'(m_axi.wlast), 64'(w_k == BURST_LEN - 1));
            mem[int'(w_base) + w_k * 4] = m_axi.wdata;
            if (w_k == BURST_LEN - 1) b_pending++;
            w_k++;
         end

         if (m_axi.bvalid && m_axi.bready) begin
            b_pending--;
`ifdef DDR_TESTER_RESP_CHK_EN
            if (m_axi.bresp != 2'b00) exp_err++;
`endif
         end

         if (m_axi.arvalid && m_axi.arready) begin
            check_eq("araddr", 64'(m_axi.araddr), 64'(ar_n * BURST_LEN * 4));
            check_eq("arlen", 64'(m_axi.arlen), 64'(BURST_LEN - 1));
            check_eq("writes_done_before_read", 64'(aw_n), 64'(cur_nb));
            r_addr_cur = m_axi.araddr;
            r_left     = BURST_LEN;
            r_beat     = 0;
            r_burst    = ar_n;
            ar_n++;
            ar_wait    = 0;
         end else if (m_axi.arvalid) begin
            ar_wait++;
         end

         if (m_axi.rvalid && m_axi.rready) begin
            if (m_axi.rdata != {2'b00, r_addr_cur}) exp_err++;
            if (rlast_flip) exp_err++;
`ifdef DDR_TESTER_RESP_CHK_EN
            if (m_axi.rresp != 2'b00) exp_err++;
`endif
            r_addr_cur = r_addr_cur + ADDR_W'(4);
            r_beat++;
            r_left--;
            r_total++;
         end

         prev_aw_stall = m_axi.awvalid && !m_axi.awready;
         prev_w_stall  = m_axi.wvalid && !m_axi.wready;
         prev_ar_stall = m_axi.arvalid && !m_axi.arready;
         prev_awaddr   = m_axi.awaddr;
         prev_araddr   = m_axi.araddr;
         prev_wdata    = m_axi.wdata;
         prev_wlast    = m_axi.wlast;
      end
   end

   task automatic set_clean();
      cfg_stall = 0; cfg_hold = 0; cfg_flip_mode = 0; cfg_flip_pct = 0;
      cfg_rlast_pct = 0; cfg_toggle = 0; cfg_restart = 0;
`ifdef DDR_TESTER_RESP_CHK_EN
      cfg_bresp_pct = 0; cfg_rresp_pct = 0;
`endif
   endtask

   task automatic kick(input int nb);
      @(posedge clk); #1;
      aw_n = 0; ar_n = 0; r_total = 0; exp_err = 0; cur_nb = nb;
      nbursts = 16'(nb);
      start   = 1'b1;
      @(posedge clk); #1;
      start   = 1'b0;
      nbursts = 16'($urandom);
      check_eq("busy_after_start", 64'(busy), 64'(1));
   endtask

   task automatic run_test(input int nb);
      int cyc;
      kick(nb);
      if (cfg_restart) begin
         nbursts = 16'd9;
         start   = 1'b1;
         @(posedge clk); #1;
         start   = 1'b0;
      end
      cyc = 0;
      while (busy && cyc < 5000) begin
         @(posedge clk); #1;
         cyc++;
      end
      check_eq("done_in_time", 64'(cyc < 5000), 64'(1));
      check_eq("read_beats_at_done", 64'(r_total), 64'(nb * BURST_LEN));
      check_eq("aw_count", 64'(aw_n), 64'(nb));
      check_eq("ar_count", 64'(ar_n), 64'(nb));
      check_eq("err_cnt", 64'(err_cnt), 64'(exp_err > 65535 ? 65535 : exp_err));
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc;
      rst = 1'b1; start = 1'b0; nbursts = 16'd0;
      set_clean();
      aw_n = 0; ar_n = 0; r_total = 0; exp_err = 0; cur_nb = 0;
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_busy", 64'(busy), 64'(0));
      check_eq("rst_err_cnt", 64'(err_cnt), 64'(0));
      check_eq("rst_awvalid", 64'(m_axi.awvalid), 64'(0));
      check_eq("rst_wvalid", 64'(m_axi.wvalid), 64'(0));
      check_eq("rst_wlast", 64'(m_axi.wlast), 64'(0));
      check_eq("rst_bready", 64'(m_axi.bready), 64'(0));
      check_eq("rst_arvalid", 64'(m_axi.arvalid), 64'(0));
      check_eq("rst_rready", 64'(m_axi.rready), 64'(0));
      check_eq("rst_awaddr", 64'(m_axi.awaddr), 64'(0));
      check_eq("rst_araddr", 64'(m_axi.araddr), 64'(0));
      check_eq("rst_wdata", 64'(m_axi.wdata), 64'(0));
      rst = 1'b0;

      // start with nbursts=0 is ignored
      @(posedge clk); #1;
      nbursts = 16'd0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check_eq("zero_nbursts_busy", 64'(busy), 64'(0));
      check_eq("zero_nbursts_awvalid", 64'(m_axi.awvalid), 64'(0));

      // single burst, all readies high
      set_clean();
      run_test(1);
      check_eq("plan_single_err", 64'(err_cnt), 64'(0));

      // three bursts, restart pulse while busy must be ignored
      cfg_restart = 1;
      run_test(3);
      check_eq("plan_three_err", 64'(err_cnt), 64'(0));

      // bit 0 of read beat 2 flipped
      set_clean(); cfg_flip_mode = 1;
      run_test(1);
      check_eq("plan_flip_one", 64'(err_cnt), 64'(1));

      // every read beat of 3 bursts flipped
      cfg_flip_mode = 2;
      run_test(3);
      check_eq("plan_flip_all", 64'(err_cnt), 64'(12));

      // address readies held off 5 cycles, wready toggling
      set_clean(); cfg_hold = 5; cfg_toggle = 1;
      run_test(2);
      check_eq("plan_stall_err", 64'(err_cnt), 64'(0));

      // randomized mixes of stalls, data flips and rlast errors
      for (int it = 0; it < 10; it++) begin
         set_clean();
         cfg_stall     = int'($urandom_range(0, 60));
         cfg_hold      = int'($urandom_range(0, 3));
         cfg_toggle    = 1'($urandom_range(0, 1));
         cfg_flip_mode = 3;
         cfg_flip_pct  = int'($urandom_range(0, 50));
         cfg_rlast_pct = int'($urandom_range(0, 30));
         cfg_restart   = 1'($urandom_range(0, 1));
         run_test(int'($urandom_range(1, 6)));
      end

      // asynchronous reset in the middle of the write data phase
      set_clean(); cfg_stall = 30;
      kick(2);
      cyc = 0;
      while (!m_axi.wvalid && cyc < 200) begin
         @(posedge clk); #1;
         cyc++;
      end
      check_eq("reached_wdata", 64'(m_axi.wvalid), 64'(1));
      @(negedge clk); #2;
      rst = 1'b1;
      #1;
      check_eq("arst_busy", 64'(busy), 64'(0));
      check_eq("arst_awvalid", 64'(m_axi.awvalid), 64'(0));
      check_eq("arst_wvalid", 64'(m_axi.wvalid), 64'(0));
      check_eq("arst_wlast", 64'(m_axi.wlast), 64'(0));
      check_eq("arst_arvalid", 64'(m_axi.arvalid), 64'(0));
      check_eq("arst_err_cnt", 64'(err_cnt), 64'(0));
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      set_clean();
      run_test(2);
      check_eq("plan_after_reset_err", 64'(err_cnt), 64'(0));

`ifdef DDR_TESTER_RESP_CHK_EN
      set_clean(); cfg_bresp_pct = 100;
      run_test(1);
      check_eq("plan_bresp_err", 64'(err_cnt), 64'(1));
      set_clean(); cfg_rresp_pct = 25; cfg_bresp_pct = 25; cfg_flip_mode = 3;
      cfg_flip_pct = 25; cfg_rlast_pct = 25; cfg_stall = 20;
      run_test(4);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
